// File: rtl/buffer_pkg.sv
// Shared definitions for the receive/transmit buffer controller.
//   state_e : read-sequencer states (3-bit encoding is fixed by the parent design)
//   RAM_RD  : ram_rw level that selects a read
//   RAM_WR  : ram_rw level that selects a write
package buffer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ADDR  = 3'd1,
    RD_DATA  = 3'd2,
    START    = 3'd3,
    WAIT_ACK = 3'd4
  } state_e;

  localparam logic RAM_RD = 1'b1;
  localparam logic RAM_WR = 1'b0;

endpackage

// File: rtl/buffer_ctrl.sv
// buffer_ctrl: runs a single-port 2^AW x DW RAM as a circular FIFO between a serial receiver
// (writer, cannot be stalled) and a serial transmitter (reader, start/ready handshake).
//
// Ports
//   clk, rstn            : clock, synchronous active-low reset
//   flush                : synchronous clear of FIFO contents and read sequencer
//   rx_valid, rx_data    : one-cycle write pulse and word from the receiver
//   tx_ready             : transmitter idle level
//   tx_start, tx_data    : one-cycle start pulse and registered word to the transmitter
//   ram_addr/rw/wdata    : RAM port (combinational), ram_rw 1 = read, 0 = write
//   ram_rdata            : RAM read data, valid the cycle after a read address
//   count, empty, full   : occupancy and flags (all from the registered count)
//   overflow             : registered one-cycle pulse after a write was dropped
module buffer_ctrl
  import buffer_pkg::*;
#(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          rx_valid,
  input  logic [DW-1:0] rx_data,
  input  logic          tx_ready,
  output logic          tx_start,
  output logic [DW-1:0] tx_data,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rw,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow
);

  localparam logic [AW:0] Depth = {1'b1, {AW{1'b0}}};

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic          overflow_q, overflow_d;

  logic          wr_acc;
  logic          pop;

  // Flags come only from the registered count, so rx_valid never reaches them combinationally.
  assign empty    = (count_q == '0);
  assign full     = (count_q == Depth);
  assign count    = count_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;

  // The receiver cannot wait: an accepted write always owns the RAM port.
  assign wr_acc = rx_valid & ~full & ~flush;
  assign pop    = (state_q == RD_DATA) & ~flush;

  // Flush also suppresses a start that would otherwise go out this cycle.
  assign tx_start = (state_q == START) & ~flush;

  always_comb begin
    ram_rw    = RAM_RD;
    ram_addr  = rd_ptr_q;
    ram_wdata = rx_data;
    if (wr_acc) begin
      ram_rw   = RAM_WR;
      ram_addr = wr_ptr_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    overflow_d = rx_valid & full & ~flush;

    if (flush) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (!empty && tx_ready) begin
            state_d = RD_ADDR;
          end
        end
        RD_ADDR: begin
          // A write stole the port this cycle; re-issue the read address next cycle.
          if (!wr_acc) begin
            state_d = RD_DATA;
          end
        end
        RD_DATA: begin
          tx_data_d = ram_rdata;
          rd_ptr_d  = rd_ptr_q + 1'b1;
          state_d   = START;
        end
        START: begin
          state_d = WAIT_ACK;
        end
        WAIT_ACK: begin
          // Wait for the transmitter to drop ready so one start maps to one word.
          if (!tx_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (wr_acc && !pop) begin
        count_d = count_q + 1'b1;
      end else if (!wr_acc && pop) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_buffer_ctrl.sv
// Self-checking bench for buffer_ctrl: behavioural RAM and transmitter models, a word queue as
// the FIFO reference, a flag table for the fill/overflow case and hand sequences for latency,
// port contention, flush and mid-operation reset.
module tb_buffer_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic          rx_valid = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          tx_ready;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic [AW-1:0] ram_addr;
  logic          ram_rw;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;

  buffer_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_ready (tx_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .ram_addr (ram_addr),
    .ram_rw   (ram_rw),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read data.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_rw == 1'b0) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Transmitter: drops ready for a few cycles after each start, optional random idle gaps.
  logic auto_en = 1'b0;
  logic man_rdy = 1'b1;
  logic auto_rdy = 1'b1;
  logic gap_en = 1'b0;
  int   busy = 0;
  always @(posedge clk) begin
    if (tx_start) begin
      auto_rdy <= 1'b0;
      busy     <= int'($urandom_range(1, 4));
    end else if (busy > 0) begin
      busy <= busy - 1;
      if (busy == 1) auto_rdy <= 1'b1;
    end else begin
      auto_rdy <= gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end
  assign tx_ready = auto_en ? auto_rdy : man_rdy;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_starts = 0;
  int            wr_idx = 0;
  logic          prev_start = 1'b0;
  logic [DW-1:0] q[$];

  typedef struct {
    logic          rv;
    logic [DW-1:0] d;
    logic [AW:0]   cnt;
    logic          full;
    logic          empty;
    logic          ovf;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, update the reference, then check after the edge.
  task automatic cyc(input logic rv, input logic [DW-1:0] d, input logic fl);
    logic kill;
    logic acc;
    logic exp_ovf;
    rx_valid = rv;
    rx_data  = d;
    flush    = fl;
    kill     = fl || !rstn;
    acc      = rv && !kill && (q.size() < DEPTH);
    exp_ovf  = rv && !kill && (q.size() >= DEPTH);
    #1;
    if (fl) chk("start_gated_by_flush", 32'(tx_start), 32'd0);
    if (acc) begin
      chk("wr_rw", 32'(ram_rw), 32'd0);
      chk("wr_addr", 32'(ram_addr), 32'(wr_idx % DEPTH));
      chk("wr_data", 32'(ram_wdata), 32'(d));
      q.push_back(d);
      wr_idx++;
    end
    if (kill) begin
      q.delete();
      wr_idx = 0;
    end
    @(posedge clk);
    #1;
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    if (tx_start) begin
      n_starts++;
      chk("start_width", 32'(prev_start), 32'd0);
      chk("start_nonempty", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        chk("tx_data", 32'(tx_data), 32'(q.pop_front()));
        chk("count_at_start", 32'(count), 32'(q.size()));
      end
    end
    prev_start = tx_start;
    rx_valid   = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() > 0 && n < budget) begin
      cyc(1'b0, '0, 1'b0);
      n++;
    end
    chk("drain_done", 32'(q.size()), 32'd0);
    repeat (6) cyc(1'b0, '0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_ram_rw"}, 32'(ram_rw), 32'd1);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s;
    int n;
    int written;

    for (int i = 0; i < 18; i++) begin
      tbl[i].rv    = (i < 17);
      tbl[i].d     = DW'(i + 1);
      tbl[i].cnt   = (i < 16) ? (AW+1)'(i + 1) : (AW+1)'(16);
      tbl[i].full  = (i >= 15);
      tbl[i].empty = 1'b0;
      tbl[i].ovf   = (i == 16);
    end

    // Reset
    rstn = 1'b0;
    repeat (2) cyc(1'b0, '0, 1'b0);
    chk_reset_vals("reset");
    rstn = 1'b1;
    repeat (2) cyc(1'b0, '0, 1'b0);

    // Single-word latency: write at t, start at t+4
    auto_en = 1'b1;
    s = n_starts;
    cyc(1'b1, 16'h00aa, 1'b0);
    chk("empty_after_write", 32'(empty), 32'd0);
    repeat (2) cyc(1'b0, '0, 1'b0);
    chk("lat_no_early_start", 32'(n_starts), 32'(s));
    cyc(1'b0, '0, 1'b0);
    chk("lat_start_t4", 32'(n_starts), 32'(s + 1));
    drain(40);

    // Three words in order
    s = n_starts;
    cyc(1'b1, 16'h1111, 1'b0);
    cyc(1'b1, 16'h2222, 1'b0);
    cyc(1'b1, 16'h3333, 1'b0);
    drain(80);
    chk("three_starts", 32'(n_starts), 32'(s + 3));
    chk("three_count", 32'(count), 32'd0);
    chk("three_empty", 32'(empty), 32'd1);

    // Fill to full with the transmitter held busy, 17th write overflows
    man_rdy = 1'b0;
    auto_en = 1'b0;
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].rv, tbl[i].d, 1'b0);
      chk("tbl_count", 32'(count), 32'(tbl[i].cnt));
      chk("tbl_full", 32'(full), 32'(tbl[i].full));
      chk("tbl_empty", 32'(empty), 32'(tbl[i].empty));
      chk("tbl_overflow", 32'(overflow), 32'(tbl[i].ovf));
    end
    auto_en = 1'b1;
    s = n_starts;
    drain(400);
    chk("full_drain_starts", 32'(n_starts), 32'(s + 16));
    chk("full_drain_empty", 32'(empty), 32'd1);

    // Write contention: two writes while the sequencer sits in RD_ADDR
    s = n_starts;
    cyc(1'b1, 16'ha0a0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b1, 16'hb1b1, 1'b0);
    cyc(1'b1, 16'hc2c2, 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("contend_no_early_start", 32'(n_starts), 32'(s));
    cyc(1'b0, '0, 1'b0);
    chk("contend_start_t6", 32'(n_starts), 32'(s + 1));
    drain(80);
    chk("contend_total", 32'(n_starts), 32'(s + 3));

    // Random fill/drain of 40 words with transmitter gaps
    gap_en  = 1'b1;
    written = 0;
    n       = 0;
    s       = n_starts;
    while ((written < 40 || q.size() > 0) && n < 4000) begin
      if (written < 40 && q.size() < 12 && $urandom_range(0, 1) == 1) begin
        cyc(1'b1, DW'($urandom), 1'b0);
        written++;
      end else begin
        cyc(1'b0, '0, 1'b0);
      end
      n++;
    end
    chk("rand_all_written", 32'(written), 32'd40);
    chk("rand_all_sent", 32'(n_starts), 32'(s + 40));
    gap_en = 1'b0;
    repeat (8) cyc(1'b0, '0, 1'b0);
    chk("rand_count", 32'(count), 32'd0);

    // Flush while in START with five words left
    auto_en = 1'b0;
    man_rdy = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1'b1, DW'(16'h5000 + i), 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("flush_pre_count6", 32'(count), 32'd6);
    man_rdy = 1'b1;
    repeat (3) cyc(1'b0, '0, 1'b0);
    chk("flush_in_start", 32'(tx_start), 32'd1);
    chk("flush_pre_count5", 32'(count), 32'd5);
    cyc(1'b1, 16'hdead, 1'b1);
    s = n_starts;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_tx_data_held", 32'(tx_data), 32'h5000);
    repeat (5) cyc(1'b0, '0, 1'b0);
    chk("flush_no_start", 32'(n_starts), 32'(s));
    chk("flush_rx_ignored", 32'(count), 32'd0);
    auto_en = 1'b1;
    cyc(1'b1, 16'h0f0f, 1'b0);
    drain(40);
    chk("post_flush_start", 32'(n_starts), 32'(s + 1));

    // Reset while waiting for the transmitter acknowledge
    auto_en = 1'b0;
    man_rdy = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'(16'h7000 + i), 1'b0);
    cyc(1'b0, '0, 1'b0);
    man_rdy = 1'b1;
    repeat (3) cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("rst_pre_count", 32'(count), 32'd3);
    rstn = 1'b0;
    cyc(1'b0, '0, 1'b0);
    chk_reset_vals("midrst");
    rstn = 1'b1;
    s = n_starts;
    repeat (8) cyc(1'b0, '0, 1'b0);
    chk("midrst_no_start", 32'(n_starts), 32'(s));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
